// File: rtl/dodge_engine_p.sv
// Falling-object dodge game engine: player/object movement, collisions, lives,
// BCD game timer and a registered per-column scan port for the display drivers.
module dodge_engine_p #(
    parameter int          COLS      = 8,
    parameter int          ROWS      = 8,
    parameter int          N_OBJ     = 3,
    parameter int          LIVES     = 3,
    parameter int          PH        = 2,
    parameter int          TIME_INIT = 30,
    parameter int          SPAWN_GAP = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     CLK,
    input  logic                     clear,
    input  logic                     tick_mv,
    input  logic                     tick_sec,
    input  logic                     pause,
    input  logic                     mode,
    input  logic                     left,
    input  logic                     right,
    input  logic [$clog2(COLS)-1:0]  scan_col,
    output logic [ROWS-1:0]          fall_col,
    output logic [ROWS-1:0]          player_col,
    output logic [1:0]               state,
    output logic [2:0]               lives,
    output logic                     hit,
    output logic [3:0]               sec_tens,
    output logic [3:0]               sec_ones
);

    localparam int L         = $clog2(COLS);
    localparam int RW        = (ROWS < 2) ? 1 : $clog2(ROWS);
    localparam int MAX_DELAY = (N_OBJ - 1) * SPAWN_GAP;
    localparam int DW        = (MAX_DELAY < 2) ? 1 : $clog2(MAX_DELAY + 1);

    localparam logic [3:0]      INIT_TENS   = 4'(TIME_INIT / 10);
    localparam logic [3:0]      INIT_ONES   = 4'(TIME_INIT % 10);
    localparam logic [ROWS-1:0] PLAYER_MASK = {ROWS{1'b1}} << (ROWS - PH);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        PAUSE = 2'b01,
        WIN   = 2'b10,
        LOSE  = 2'b11
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;

    logic [15:0]     lfsr;
    logic            mode_q;
    logic [L-1:0]    player_lane;
    logic [L-1:0]    player_nxt;

    logic            obj_active [N_OBJ];
    logic            active_nxt [N_OBJ];
    logic [RW-1:0]   obj_row    [N_OBJ];
    logic [RW-1:0]   row_nxt    [N_OBJ];
    logic [L-1:0]    obj_lane   [N_OBJ];
    logic [L-1:0]    lane_nxt   [N_OBJ];
    logic [DW-1:0]   obj_delay  [N_OBJ];
    logic [DW-1:0]   delay_nxt  [N_OBJ];

    logic            go;
    logic            mv_en;
    logic            sec_en;
    logic            collide;
    logic            lose_evt;
    logic            win_evt;
    logic [2:0]      lives_nxt;
    logic [3:0]      tens_nxt;
    logic [3:0]      ones_nxt;
    logic [ROWS-1:0] fall_bits;

    // The game only advances in RUN with pause released; a rising pause freezes at once.
    assign go     = (cur_state == RUN) && !pause;
    assign mv_en  = go && tick_mv;
    assign sec_en = go && tick_sec;

    always_ff @(posedge CLK) begin
        if (clear) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            RUN: begin
                if (lose_evt) begin
                    nxt_state = LOSE;
                end else if (win_evt) begin
                    nxt_state = WIN;
                end else if (pause) begin
                    nxt_state = PAUSE;
                end
            end
            PAUSE: begin
                if (!pause) begin
                    nxt_state = RUN;
                end
            end
            default: nxt_state = cur_state;
        endcase
    end

    always_comb begin
        state = cur_state;
    end

    // Fibonacci LFSR, taps 16,14,13,11; free-running so spawn lanes vary with play timing.
    always_ff @(posedge CLK) begin
        if (clear) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        player_nxt = player_lane;
        collide    = 1'b0;
        for (int k = 0; k < N_OBJ; k++) begin
            active_nxt[k] = obj_active[k];
            row_nxt[k]    = obj_row[k];
            lane_nxt[k]   = obj_lane[k];
            delay_nxt[k]  = obj_delay[k];
        end
        if (mv_en) begin
            if (right && !left && (player_lane != L'(COLS - 1))) begin
                player_nxt = player_lane + L'(1);
            end else if (left && !right && (player_lane != '0)) begin
                player_nxt = player_lane - L'(1);
            end
            for (int k = 0; k < N_OBJ; k++) begin
                if (!obj_active[k]) begin
                    if (obj_delay[k] != '0) begin
                        delay_nxt[k] = obj_delay[k] - DW'(1);
                    end else begin
                        active_nxt[k] = 1'b1;
                        row_nxt[k]    = '0;
                        lane_nxt[k]   = lfsr[k*L +: L];
                    end
                end else if (obj_row[k] == RW'(ROWS - 1)) begin
                    active_nxt[k] = 1'b0;
                    delay_nxt[k]  = '0;
                end else begin
                    row_nxt[k] = obj_row[k] + RW'(1);
                end
            end
            // Collision is judged on the post-move positions of both player and objects.
            for (int k = 0; k < N_OBJ; k++) begin
                if (active_nxt[k] && (lane_nxt[k] == player_nxt) &&
                    (row_nxt[k] >= RW'(ROWS - PH))) begin
                    collide = 1'b1;
                end
            end
            if (collide) begin
                for (int k = 0; k < N_OBJ; k++) begin
                    active_nxt[k] = 1'b0;
                    delay_nxt[k]  = DW'(k * SPAWN_GAP);
                end
            end
        end
    end

    always_comb begin
        lives_nxt = lives;
        lose_evt  = 1'b0;
        if (collide) begin
            lives_nxt = lives - 3'd1;
            lose_evt  = (lives == 3'd1);
        end
    end

    always_comb begin
        tens_nxt = sec_tens;
        ones_nxt = sec_ones;
        win_evt  = 1'b0;
        if (sec_en) begin
            if (!mode_q) begin
                if (sec_ones != 4'd9) begin
                    ones_nxt = sec_ones + 4'd1;
                end else if (sec_tens != 4'd9) begin
                    tens_nxt = sec_tens + 4'd1;
                    ones_nxt = 4'd0;
                end
            end else begin
                if (sec_ones != 4'd0) begin
                    ones_nxt = sec_ones - 4'd1;
                end else if (sec_tens != 4'd0) begin
                    tens_nxt = sec_tens - 4'd1;
                    ones_nxt = 4'd9;
                end
                win_evt = (tens_nxt == 4'd0) && (ones_nxt == 4'd0);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            mode_q      <= mode;
            player_lane <= L'(COLS / 2 - 1);
            lives       <= 3'(LIVES);
            hit         <= 1'b0;
            sec_tens    <= mode ? INIT_TENS : 4'd0;
            sec_ones    <= mode ? INIT_ONES : 4'd0;
            for (int k = 0; k < N_OBJ; k++) begin
                obj_active[k] <= 1'b0;
                obj_row[k]    <= '0;
                obj_lane[k]   <= '0;
                obj_delay[k]  <= DW'(k * SPAWN_GAP);
            end
        end else begin
            player_lane <= player_nxt;
            lives       <= lives_nxt;
            hit         <= collide;
            sec_tens    <= tens_nxt;
            sec_ones    <= ones_nxt;
            for (int k = 0; k < N_OBJ; k++) begin
                obj_active[k] <= active_nxt[k];
                obj_row[k]    <= row_nxt[k];
                obj_lane[k]   <= lane_nxt[k];
                obj_delay[k]  <= delay_nxt[k];
            end
        end
    end

    always_comb begin
        fall_bits = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            if (obj_active[k] && (obj_lane[k] == scan_col)) begin
                fall_bits[obj_row[k]] = 1'b1;
            end
        end
    end

    // Display read is registered so the drivers see a stable column one cycle after selecting it.
    always_ff @(posedge CLK) begin
        if (clear) begin
            fall_col   <= '0;
            player_col <= '0;
        end else begin
            fall_col   <= fall_bits;
            player_col <= (player_lane == scan_col) ? PLAYER_MASK : '0;
        end
    end

endmodule

// File: tb/tb_dodge_engine_p.sv
// Directed bench for dodge_engine_p: reset, timer in both modes, player moves,
// collisions down to LOSE, pause freeze and the free-running spawn LFSR.
module tb_dodge_engine_p;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       CLK;
    logic       clear;
    logic       tick_mv;
    logic       tick_sec;
    logic       pause;
    logic       mode;
    logic       left;
    logic       right;
    logic [2:0] scan_col;
    logic [7:0] fall_col;
    logic [7:0] player_col;
    logic [1:0] state;
    logic [2:0] lives;
    logic       hit;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    logic [15:0] m_lfsr;
    int total = 0;
    int bad   = 0;

    dodge_engine_p #(
        .COLS(8), .ROWS(8), .N_OBJ(3), .LIVES(3), .PH(2),
        .TIME_INIT(30), .SPAWN_GAP(3), .LFSR_SEED(SEED)
    ) dut (
        .CLK(CLK), .clear(clear), .tick_mv(tick_mv), .tick_sec(tick_sec),
        .pause(pause), .mode(mode), .left(left), .right(right),
        .scan_col(scan_col), .fall_col(fall_col), .player_col(player_col),
        .state(state), .lives(lives), .hit(hit),
        .sec_tens(sec_tens), .sec_ones(sec_ones)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, reloaded on clear.
    always @(posedge CLK) begin
        if (clear) begin
            m_lfsr <= SEED;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic mv, input logic sec, input logic l,
                                  input logic r, input int n);
        repeat (n) begin
            tick_mv  = mv;
            tick_sec = sec;
            left     = l;
            right    = r;
            @(posedge CLK);
            #1;
            tick_mv  = 1'b0;
            tick_sec = 1'b0;
            left     = 1'b0;
            right    = 1'b0;
        end
    endtask

    task automatic do_clear(input logic m);
        mode  = m;
        clear = 1'b1;
        @(posedge CLK);
        #1;
        clear = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic read_col(input logic [2:0] c);
        scan_col = c;
        idle(1);
    endtask

    task automatic wait_lane(input logic [2:0] want);
        int n = 0;
        while ((m_lfsr[2:0] != want) && (n < 500)) begin
            idle(1);
            n++;
        end
        check_output("lane_wait_bound", 16'(n < 500), 16'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] lane_exp;
        int         v;
        clear = 0; tick_mv = 0; tick_sec = 0; pause = 0;
        mode = 0; left = 0; right = 0; scan_col = 3'd3;

        $display("[TB] reset and idle");
        do_clear(1'b0);
        idle(5);
        check_output("rst_state", 16'(state), 16'd0);
        check_output("rst_lives", 16'(lives), 16'd3);
        check_output("rst_tens", 16'(sec_tens), 16'd0);
        check_output("rst_ones", 16'(sec_ones), 16'd0);
        check_output("rst_hit", 16'(hit), 16'd0);
        check_output("rst_player3", 16'(player_col), 16'hC0);
        check_output("rst_fall3", 16'(fall_col), 16'h00);
        read_col(3'd2);
        check_output("rst_player2", 16'(player_col), 16'h00);

        $display("[TB] clear overrides a same-cycle move");
        tick_mv = 1; right = 1; clear = 1;
        @(posedge CLK);
        #1;
        tick_mv = 0; right = 0; clear = 0;
        read_col(3'd4);
        check_output("ovr_player4", 16'(player_col), 16'h00);
        read_col(3'd3);
        check_output("ovr_player3", 16'(player_col), 16'hC0);

        $display("[TB] count-up timer");
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(0, 1, 0, 0, 1);
            check_output("up_tens", 16'(sec_tens), 16'(i / 10));
            check_output("up_ones", 16'(sec_ones), 16'(i % 10));
        end
        apply_stimulus(0, 1, 0, 0, 95);
        check_output("sat_tens", 16'(sec_tens), 16'd9);
        check_output("sat_ones", 16'(sec_ones), 16'd9);
        check_output("sat_state", 16'(state), 16'd0);

        $display("[TB] countdown timer");
        do_clear(1'b1);
        check_output("dn_init_tens", 16'(sec_tens), 16'd3);
        check_output("dn_init_ones", 16'(sec_ones), 16'd0);
        for (int i = 1; i <= 30; i++) begin
            apply_stimulus(0, 1, 0, 0, 1);
            v = 30 - i;
            check_output("dn_tens", 16'(sec_tens), 16'(v / 10));
            check_output("dn_ones", 16'(sec_ones), 16'(v % 10));
            check_output("dn_state", 16'(state), (i == 30) ? 16'd2 : 16'd0);
        end
        apply_stimulus(1, 1, 0, 1, 3);
        check_output("win_tens", 16'(sec_tens), 16'd0);
        check_output("win_ones", 16'(sec_ones), 16'd0);
        check_output("win_state", 16'(state), 16'd2);
        read_col(3'd3);
        check_output("win_player", 16'(player_col), 16'hC0);

        $display("[TB] player movement");
        do_clear(1'b0);
        scan_col = 3'd7;
        apply_stimulus(1, 0, 0, 1, 10);
        idle(1);
        check_output("mv_right7", 16'(player_col), 16'hC0);
        read_col(3'd6);
        check_output("mv_right6", 16'(player_col), 16'h00);
        apply_stimulus(1, 0, 1, 1, 3);
        read_col(3'd7);
        check_output("mv_both7", 16'(player_col), 16'hC0);
        apply_stimulus(1, 0, 1, 0, 2);
        read_col(3'd5);
        check_output("mv_left5", 16'(player_col), 16'hC0);
        read_col(3'd7);
        check_output("mv_left7", 16'(player_col), 16'h00);
        check_output("mv_state", 16'(state), 16'd0);

        $display("[TB] first collision");
        do_clear(1'b0);
        scan_col = 3'd3;
        wait_lane(3'd3);
        apply_stimulus(1, 0, 0, 0, 6);
        idle(1);
        check_output("pre_fall_low", 16'(fall_col[7:3]), 16'b00100);
        check_output("pre_hit", 16'(hit), 16'd0);
        check_output("pre_lives", 16'(lives), 16'd3);
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("hit_pulse", 16'(hit), 16'd1);
        check_output("hit_lives", 16'(lives), 16'd2);
        check_output("hit_state", 16'(state), 16'd0);
        idle(1);
        check_output("hit_drop", 16'(hit), 16'd0);
        for (int c = 0; c < 8; c++) begin
            read_col(3'(c));
            check_output("post_fall", 16'(fall_col), 16'h00);
        end

        $display("[TB] collisions down to LOSE");
        for (int rnd = 2; rnd <= 3; rnd++) begin
            wait_lane(3'd3);
            apply_stimulus(1, 0, 0, 0, 7);
            check_output("rnd_hit", 16'(hit), 16'd1);
            check_output("rnd_lives", 16'(lives), 16'(3 - rnd));
            check_output("rnd_state", 16'(state), (rnd == 3) ? 16'd3 : 16'd0);
        end
        apply_stimulus(1, 1, 0, 1, 4);
        check_output("lose_state", 16'(state), 16'd3);
        check_output("lose_lives", 16'(lives), 16'd0);
        check_output("lose_tens", 16'(sec_tens), 16'd0);
        check_output("lose_ones", 16'(sec_ones), 16'd0);
        check_output("lose_hit", 16'(hit), 16'd0);
        read_col(3'd3);
        check_output("lose_player", 16'(player_col), 16'hC0);
        do_clear(1'b0);
        check_output("restart_state", 16'(state), 16'd0);
        check_output("restart_lives", 16'(lives), 16'd3);

        $display("[TB] pause freeze");
        apply_stimulus(0, 1, 0, 0, 5);
        apply_stimulus(1, 0, 0, 1, 2);
        pause = 1'b1;
        idle(1);
        check_output("pause_state", 16'(state), 16'd1);
        apply_stimulus(1, 1, 0, 1, 20);
        check_output("pause_tens", 16'(sec_tens), 16'd0);
        check_output("pause_ones", 16'(sec_ones), 16'd5);
        check_output("pause_lives", 16'(lives), 16'd3);
        check_output("pause_state2", 16'(state), 16'd1);
        read_col(3'd5);
        check_output("pause_player", 16'(player_col), 16'hC0);
        pause = 1'b0;
        idle(1);
        check_output("resume_state", 16'(state), 16'd0);
        apply_stimulus(1, 0, 0, 0, 1);
        lane_exp = m_lfsr[5:3];
        apply_stimulus(1, 0, 0, 0, 1);
        read_col(lane_exp);
        check_output("spawn_after_pause", 16'(fall_col[0]), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
